// File: rtl/text_fetch_scheduler_pkg.sv
// Shared cell layout and text-mode geometry for the
// 80x48 character fetch path.
package text_fetch_scheduler_pkg;

  localparam int CELL_W = 8;
  localparam int CELL_H = 10;
  localparam int TEXT_COLUMNS = 80;
  localparam int TEXT_ROWS = 48;
  localparam int CELL_UNDERLINE_BIT = 8;
  localparam int CELL_INVERT_BIT = 9;

  typedef struct packed {
    logic [5:0] rsvd;
    logic       invert;
    logic       underline;
    logic [7:0] code;
  } cell_t;

endpackage

// File: rtl/text_row_counter.sv
// Scan line within cell and row base address, advanced
// at end of line; frozen after reset until a frame wrap.
module text_row_counter
  import text_fetch_scheduler_pkg::*;
#(
  parameter int COLUMNS = TEXT_COLUMNS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_end,
  input  logic              frame_end,
  input  logic              text_line,
  output logic [3:0]        ychar_cnt,
  output logic [ADDR_W-1:0] row_base
);

  logic synced;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      synced <= 1'b0;
      ychar_cnt <= '0;
      row_base <= '0;
    end else if (line_end) begin
      if (frame_end) begin
        synced <= 1'b1;
        ychar_cnt <= '0;
        row_base <= '0;
      end else if (text_line && synced) begin
        if (ychar_cnt == 4'(CELL_H - 1)) begin
          ychar_cnt <= '0;
          row_base <= row_base + ADDR_W'(COLUMNS);
        end else begin
          ychar_cnt <= ychar_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/text_fetch_scheduler.sv
// Cell prefetch and video RAM arbitration feeding the
// character generator; display reads always win the port.
module text_fetch_scheduler
  import text_fetch_scheduler_pkg::*;
#(
  parameter int COLUMNS = TEXT_COLUMNS,
  parameter int ROWS = TEXT_ROWS,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [2:0]        xchar,
  output logic [3:0]        ychar,
  output logic [7:0]        character_index,
  output logic              underline,
  output logic              invert,
  output logic              char_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  output logic              host_ack
);

  localparam int TEXT_W = COLUMNS * CELL_W;
  localparam int TEXT_H = ROWS * CELL_H;
  localparam int CELLS = COLUMNS * ROWS;

  logic line_end, frame_end, text_line, next_text;
  logic slot_col, slot_line, display_slot;
  logic visible, rd_pending, host_ok;
  logic [3:0] ychar_cnt;
  logic [ADDR_W-1:0] row_base, col_addr;
  logic [ADDR_W-1:0] line_addr, addr_q;
  cell_t rd_word, shadow, cell_q;
  logic [5:0] rsvd_unused;

  assign line_end = pixel_x == 10'(H_TOTAL - 1);
  assign frame_end = pixel_y == 10'(V_TOTAL - 1);
  assign text_line = pixel_y < 10'(TEXT_H);
  assign next_text = frame_end
                   || pixel_y < 10'(TEXT_H - 1);
  assign visible = text_line
                 && pixel_x < 10'(TEXT_W);

  text_row_counter #(
    .COLUMNS(COLUMNS),
    .ADDR_W(ADDR_W)
  ) u_rows (
    .clk(clk),
    .reset(reset),
    .line_end(line_end),
    .frame_end(frame_end),
    .text_line(text_line),
    .ychar_cnt(ychar_cnt),
    .row_base(row_base)
  );

  // Cell n+1 is read mid-cell n; column 0 is read near line end
  assign slot_col = pixel_x[2:0] == 3'd5
                  && pixel_x < 10'(TEXT_W - CELL_W)
                  && text_line;
  assign slot_line = pixel_x == 10'(H_TOTAL - 3)
                   && next_text;
  assign display_slot = slot_col | slot_line;

  assign col_addr = row_base
                  + ADDR_W'(pixel_x[9:3])
                  + ADDR_W'(1);
  assign line_addr = frame_end ? '0
                   : ychar_cnt == 4'(CELL_H - 1)
                   ? row_base + ADDR_W'(COLUMNS)
                   : row_base;

  assign host_ack = host_req & ~display_slot & ~reset;
  assign host_ok = {1'b0, host_addr}
                 < (ADDR_W + 1)'(CELLS);
  assign ram_we = host_ack & host_ok;
  assign ram_wdata = host_wdata;

  always_comb begin
    ram_addr = addr_q;
    unique case (1'b1)
      slot_col:  ram_addr = col_addr;
      slot_line: ram_addr = line_addr;
      host_ack:  ram_addr = host_addr;
      default:   ram_addr = addr_q;
    endcase
  end

  assign rd_word = cell_t'(ram_rdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      rd_pending <= 1'b0;
      shadow <= '0;
      cell_q <= '0;
      xchar <= '0;
      ychar <= '0;
      char_valid <= 1'b0;
    end else begin
      addr_q <= ram_addr;
      rd_pending <= display_slot;
      if (rd_pending) shadow <= rd_word;
      if (pixel_x[2:0] == 3'd0) cell_q <= shadow;
      xchar <= pixel_x[2:0];
      ychar <= ychar_cnt;
      char_valid <= visible;
    end
  end

  assign character_index = char_valid ? cell_q.code : 8'h00;
  assign underline = char_valid & cell_q.underline;
  assign invert = char_valid & cell_q.invert;
  assign rsvd_unused = cell_q.rsvd;

endmodule

// File: tb/tb_text_fetch_scheduler.sv
// Bench for text_fetch_scheduler: vector table, directed
// corner sequences and randomized host traffic vs model.
module tb_text_fetch_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] xchar;
  logic [3:0] ychar;
  logic [7:0] character_index;
  logic underline, invert, char_valid;
  logic [11:0] ram_addr;
  logic ram_we;
  logic [15:0] ram_wdata, ram_rdata;
  logic host_req;
  logic [11:0] host_addr;
  logic [15:0] host_wdata;
  logic host_ack;

  text_fetch_scheduler dut (
    .clk(clk),
    .reset(reset),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .xchar(xchar),
    .ychar(ychar),
    .character_index(character_index),
    .underline(underline),
    .invert(invert),
    .char_valid(char_valid),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .host_req(host_req),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_ack(host_ack)
  );

  always #5 clk = ~clk;

  // Synchronous single-port video RAM
  logic [15:0] vram [4096] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (ram_we) vram[ram_addr] <= ram_wdata;
    ram_rdata <= vram[ram_addr];
  end

  logic [15:0] mem [4096];
  bit synced_m;
  bit last_ack;
  logic [11:0] last_addr;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         x;
    logic [7:0] idx;
    logic       ul;
    logic       inv;
    logic       vld;
    logic [2:0] xc;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0h expected %0h",
                 name, act, exp);
    end
  endtask

  function automatic bit slot_m(input int x, input int y);
    return (x % 8 == 5 && x < 632 && y < 480)
        || (x == 797 && (y == 524 || y < 479));
  endfunction

  // One pixel clock; host side checked mid-cycle
  task automatic step(input int x, input int y);
    bit ea;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    @(negedge clk);
    last_addr = ram_addr;
    last_ack = 1'b0;
    if (host_req) begin
      ea = !slot_m(x, y);
      check("host_ack", 32'(host_ack), 32'(ea));
      check("ram_we", 32'(ram_we),
            32'(ea && host_addr < 12'd3840));
      if (ea && host_addr < 12'd3840) begin
        check("ram_addr", 32'(ram_addr), 32'(host_addr));
        mem[host_addr] = host_wdata;
      end
      last_ack = ea;
    end else begin
      check("ram_we idle", 32'(ram_we), 32'd0);
    end
    @(posedge clk);
    #1;
    if (x == 799 && y == 524) synced_m = 1'b1;
  endtask

  task automatic check_pix(input int x, input int y);
    bit vis;
    int row;
    logic [15:0] w;
    logic [13:0] act, exp;
    vis = x < 640 && y < 480;
    row = synced_m ? y / 10 : 0;
    w = vis ? mem[row * 80 + x / 8] : 16'h0000;
    act = {char_valid, xchar, underline, invert,
           character_index};
    exp = {vis, 3'(x % 8), w[8], w[9], w[7:0]};
    check($sformatf("pix x=%0d y=%0d", x, y),
          32'(act), 32'(exp));
    if (y < 480)
      check($sformatf("ychar y=%0d", y), 32'(ychar),
            32'(synced_m ? y % 10 : 0));
  endtask

  task automatic hw(input int a, input logic [15:0] d);
    host_req = 1'b1;
    host_addr = 12'(a);
    host_wdata = d;
    step(0, 500);
    host_req = 1'b0;
  endtask

  initial begin
    int x, y, bad;
    tbl[0] = '{7,   8'h00, 1'b0, 1'b0, 1'b1, 3'd7};
    tbl[1] = '{8,   8'h41, 1'b1, 1'b1, 1'b1, 3'd0};
    tbl[2] = '{15,  8'h41, 1'b1, 1'b1, 1'b1, 3'd7};
    tbl[3] = '{16,  8'h13, 1'b1, 1'b0, 1'b1, 3'd0};
    tbl[4] = '{24,  8'h00, 1'b0, 1'b0, 1'b1, 3'd0};
    tbl[5] = '{639, 8'h7E, 1'b0, 1'b1, 1'b1, 3'd7};
    tbl[6] = '{640, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0};
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    synced_m = 1'b0;

    reset = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    host_req = 1'b1;
    host_addr = 12'd5;
    host_wdata = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset host_ack", 32'(host_ack), 0);
    check("reset ram_we", 32'(ram_we), 0);
    check("reset outs", 32'({xchar, ychar, character_index,
          underline, invert, char_valid}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    host_req = 1'b0;

    hw(1, 16'h0341);
    hw(2, 16'h0113);
    hw(79, 16'h027E);

    // Line 0 sweep against the vector table
    for (int px = 0; px < 800; px++) begin
      step(px, 0);
      for (int k = 0; k < 7; k++)
        if (tbl[k].x == px)
          check($sformatf("vec x=%0d", px),
                32'({character_index, underline, invert,
                     char_valid, xchar, ychar}),
                32'({tbl[k].idx, tbl[k].ul, tbl[k].inv,
                     tbl[k].vld, tbl[k].xc, 4'd0}));
    end

    // Host request held through phase-5 slots
    host_req = 1'b1;
    host_addr = 12'd5;
    host_wdata = 16'h0042;
    for (int px = 0; px < 48; px++) step(px, 2);
    check("vram[5]", 32'(vram[5]), 32'h0042);

    // Out-of-range host write is acked and dropped
    host_addr = 12'd3840;
    host_wdata = 16'hFFFF;
    step(100, 2);
    host_req = 1'b0;
    check("vram[3840]", 32'(vram[3840]), 0);
    step(102, 2);
    check("addr hold", 32'(last_addr), 32'd3840);

    // Random host traffic against random beam positions
    for (int i = 0; i < 3000; i++) begin
      if (!host_req && $urandom_range(0, 1) == 1) begin
        host_req = 1'b1;
        host_addr = 12'($urandom_range(0, 4095));
        host_wdata = 16'($urandom);
      end
      case ($urandom_range(0, 3))
        0: x = 797;
        1: x = $urandom_range(0, 79) * 8 + 5;
        default: x = $urandom_range(0, 799);
      endcase
      y = ($urandom_range(0, 7) == 0) ? 524
        : $urandom_range(0, 524);
      step(x, y);
      if (last_ack) host_req = 1'b0;
    end
    host_req = 1'b0;
    bad = 0;
    for (int a = 0; a < 4096; a++)
      if (vram[a] !== mem[a]) bad++;
    check("vram image", 32'(bad), 0);

    hw(80, 16'h0020);

    // Frame wrap then text lines 0..21 pixel by pixel
    for (int li = -1; li <= 21; li++) begin
      y = (li < 0) ? 524 : li;
      for (int px = 0; px < 800; px++) begin
        step(px, y);
        check_pix(px, y);
        if (y == 9 && px == 797)
          check("prefetch addr", 32'(last_addr), 32'd80);
        if (y == 9 && px == 799)
          check("ychar line 9", 32'(ychar), 32'd9);
        if (y == 10 && px == 0)
          check("line 10 cell 0",
                32'({ychar, character_index}),
                32'({4'd0, 8'h20}));
      end
    end

    // Asynchronous reset mid-frame
    host_req = 1'b1;
    host_addr = 12'd7;
    host_wdata = 16'hBEEF;
    step(299, 200);
    check("pre-reset xchar", 32'(xchar), 32'd3);
    pixel_x = 10'd300;
    #2;
    reset = 1'b1;
    #1;
    check("reset mid outs", 32'({xchar, ychar,
          character_index, underline, invert, char_valid}), 0);
    check("reset mid host", 32'({host_ack, ram_we}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    host_req = 1'b0;
    synced_m = 1'b0;
    for (int px = 301; px < 800; px++) step(px, 200);
    for (int ly = 201; ly <= 211; ly++)
      for (int px = 0; px < 800; px++) begin
        step(px, ly);
        check_pix(px, ly);
      end

    // Vertical blanking: only the line-524 prefetch blocks host
    host_req = 1'b1;
    host_addr = 12'd3840;
    host_wdata = 16'h0001;
    for (int ly = 480; ly <= 524; ly++)
      for (int px = 640; px < 800; px++) begin
        step(px, ly);
        check("blank outs", 32'({char_valid,
              character_index, underline, invert}), 0);
      end
    host_req = 1'b0;

    // Counters resume after the frame wrap
    for (int ly = 0; ly <= 10; ly++)
      for (int px = 0; px < 800; px++) begin
        step(px, ly);
        check_pix(px, ly);
      end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
